uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Clocking SHALL be one clock, and reset SHALL be synchronous and active-high.
REQ-002 Parameter DATA_W, default 8, SHALL set the byte width per requester.
REQ-003 Parameter TIMEOUT, default 4096, SHALL set the WAIT_DONE watchdog limit in clk cycles, with minimum 2.
REQ-004 Parameter GAP_CYC, default 16, SHALL set the idle cycles between frames; 0 disables the gap.
REQ-005 Port clk, input, 1 bit, SHALL be the single clock, driven by the baud-tick clock shared with uart_tx.
REQ-006 Port reset, input, 1 bit, SHALL be the synchronous active-high reset.
REQ-007 Port req_valid, input, 3 bits, SHALL be the per-requester byte-offer signal: 0 = switch/button, 1 = keyboard rx, 2 = board rx.
REQ-008 Port req_data, input, 3*DATA_W bits, SHALL carry requester i's byte at bits [DATA_W*i +: DATA_W].
REQ-009 Port req_ready, output, 3 bits, SHALL be high when requester i's holding slot is empty.
REQ-010 Port tx_data, output, DATA_W bits, SHALL be the byte presented to uart_tx.
REQ-011 Port tx_start, output, 1 bit, SHALL be the one-cycle start pulse to uart_tx.
REQ-012 Port tx_done, input, 1 bit, SHALL be the frame-complete indication from uart_tx.
REQ-013 Port grant_id, output, 2 bits, SHALL hold the index of the most recent granted requester.
REQ-014 Port busy, output, 1 bit, SHALL be high in any state other than IDLE.
REQ-015 Port timeout, output, 1 bit, SHALL pulse for one cycle when the watchdog expires.

Function
REQ-016 Each requester SHALL own a one-byte holding slot with a full flag.
- req_ready[i] = ~full[i], combinational from the register.
REQ-017 A byte SHALL be accepted on a clock edge where req_valid[i] & req_ready[i].
- On acceptance, full[i] sets and the data is captured.
- req_valid while full is ignored; no overwrite, no loss.
REQ-018 The FSM SHALL have the states IDLE, WAIT_DONE and GAP, with these transitions:
- IDLE -> WAIT_DONE when any full[i].
- WAIT_DONE -> GAP on tx_done or timeout.
- GAP -> IDLE after GAP_CYC cycles.
- WAIT_DONE -> IDLE directly when GAP_CYC = 0.
REQ-019 On the IDLE->WAIT_DONE edge, the block SHALL perform the grant:
- Select the winner, register tx_data = slot byte and grant_id = winner.
- Clear full[winner].
- Drive tx_start high for exactly the following cycle.
REQ-020 Latency SHALL be as follows:
- With the FSM in IDLE, tx_start asserts in the second cycle after the accepting edge.
- req_ready[winner] returns high in the cycle after the grant edge.
REQ-021 A slot freed at grant SHALL be able to accept a new byte on the next edge, independent of FSM state.
REQ-022 tx_done SHALL be honoured only in WAIT_DONE and ignored in IDLE and GAP.
- tx_done coincident with the tx_start cycle counts.
REQ-023 The watchdog SHALL count WAIT_DONE cycles from 0.
- On reaching TIMEOUT-1 without tx_done: pulse timeout, leave WAIT_DONE as if done, and discard the byte.
REQ-024 The GAP counter SHALL count 0..GAP_CYC-1 and then return to IDLE.
REQ-025 Simultaneous acceptance on several requesters in one edge SHALL capture all of them.
REQ-026 Arbitration SHALL consider only slots full at the IDLE evaluation edge.

Reset
REQ-027 On reset the block SHALL take these values:
- full = 000, req_ready = 111, FSM = IDLE.
- tx_start = 0, tx_data = 0, grant_id = 2, busy = 0, timeout = 0.
- Counters = 0, round-robin pointer = 2.
REQ-028 Reset mid-frame (WAIT_DONE or GAP) SHALL discard all held bytes.
- tx_start SHALL NOT pulse in the cycle after reset.

Configuration
REQ-029 Macro TXARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
- Defined: round-robin. Search starts at grant_id+1 mod 3, wraps 2->0, and picks the first full slot.
- Undefined: fixed priority, with requester 0 > 1 > 2 and grant_id still updated.

Verification
REQ-030 Reset then single byte: offer req 1 byte 0x41 -> tx_start pulses once 2 cycles later with tx_data = 0x41, grant_id = 1, and req_ready = 111 thereafter.
REQ-031 All three full in the same edge (0x10, 0x20, 0x30) with tx_done returned 10 cycles after each start -> RR order 0,1,2 (0x10, 0x20, 0x30); fixed priority gives the same order. Refill req 0 during the first frame: RR yields 1,2,0, fixed yields 0,1,2 ... starvation of 2 is visible.
REQ-032 tx_done never asserted, TIMEOUT=8 -> timeout pulses 8 cycles after tx_start, busy stays through GAP, then the next slot is granted.
REQ-033 GAP_CYC=16 -> consecutive tx_start pulses are at least 1+latency(done)+16+1 cycles apart; GAP_CYC=0 -> next tx_start 2 cycles after tx_done.
REQ-034 Reset asserted in WAIT_DONE with two slots full -> all outputs at reset values next cycle, and no tx_start follows without a new offer.
REQ-035 req_valid held high on a full slot for 20 cycles with changing data -> only the originally accepted byte is transmitted, and the next byte is accepted on the first edge req_ready is high.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Three-requester byte arbiter in front of a single uart_tx: one holding slot per requester,
// IDLE/WAIT_DONE/GAP sequencer with a watchdog. Define TXARB_ROUND_ROBIN_EN for round-robin, else fixed priority 0>1>2.
module uart_tx_arbiter #(
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 4096,
   parameter int GAP_CYC = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [2:0]          req_valid,
   input  logic [3*DATA_W-1:0] req_data,
   output logic [2:0]          req_ready,
   output logic [DATA_W-1:0]   tx_data,
   output logic                tx_start,
   input  logic                tx_done,
   output logic [1:0]          grant_id,
   output logic                busy,
   output logic                timeout
);
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam logic [TW-1:0] WD_LAST  = TW'(TIMEOUT - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

   typedef enum logic [1:0] { IDLE = 2'd0, WAIT_DONE = 2'd1, GAP = 2'd2 } state_t;

   state_t                 state_q, state_d;
   logic [2:0]             full_q, full_d;
   logic [2:0][DATA_W-1:0] slot_q, slot_d;
   logic [DATA_W-1:0]      tx_data_q, tx_data_d;
   logic [1:0]             grant_q, grant_d;
   logic                   tx_start_q, tx_start_d;
   logic                   timeout_q, timeout_d;
   logic [TW-1:0]          wd_q, wd_d;
   logic [GW-1:0]          gap_q, gap_d;
   logic [1:0]             winner;

   // Winner is chosen only from slots already registered full, never from this cycle's offers.
`ifdef TXARB_ROUND_ROBIN_EN
   logic [1:0] rr_idx;
   logic       rr_found;
   always_comb begin
      winner   = 2'd0;
      rr_idx   = grant_q;
      rr_found = 1'b0;
      for (int k = 0; k < 3; k++) begin
         rr_idx = (rr_idx == 2'd2) ? 2'd0 : rr_idx + 2'd1;
         if (!rr_found && full_q[rr_idx]) begin
            winner   = rr_idx;
            rr_found = 1'b1;
         end
      end
   end
`else
   always_comb begin
      if (full_q[0])      winner = 2'd0;
      else if (full_q[1]) winner = 2'd1;
      else                winner = 2'd2;
   end
`endif

   always_comb begin
      state_d    = state_q;
      full_d     = full_q;
      slot_d     = slot_q;
      tx_data_d  = tx_data_q;
      grant_d    = grant_q;
      tx_start_d = 1'b0;
      timeout_d  = 1'b0;
      wd_d       = wd_q;
      gap_d      = gap_q;

      for (int i = 0; i < 3; i++) begin
         if (req_valid[i] && !full_q[i]) begin
            full_d[i] = 1'b1;
            slot_d[i] = req_data[DATA_W*i +: DATA_W];
         end
      end

      case (state_q)
         IDLE: begin
            if (|full_q) begin
               state_d        = WAIT_DONE;
               tx_data_d      = slot_q[winner];
               grant_d        = winner;
               full_d[winner] = 1'b0;
               tx_start_d     = 1'b1;
               wd_d           = '0;
            end
         end
         WAIT_DONE: begin
            // A watchdog expiry is treated exactly like a completed frame; the byte is dropped.
            if (tx_done || wd_q == WD_LAST) begin
               timeout_d = !tx_done;
               wd_d      = '0;
               gap_d     = '0;
               state_d   = (GAP_CYC == 0) ? IDLE : GAP;
            end else begin
               wd_d = wd_q + TW'(1);
            end
         end
         GAP: begin
            if (gap_q == GAP_LAST) begin
               gap_d   = '0;
               state_d = IDLE;
            end else begin
               gap_d = gap_q + GW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         full_q     <= '0;
         slot_q     <= '0;
         tx_data_q  <= '0;
         grant_q    <= 2'd2;
         tx_start_q <= 1'b0;
         timeout_q  <= 1'b0;
         wd_q       <= '0;
         gap_q      <= '0;
      end else begin
         state_q    <= state_d;
         full_q     <= full_d;
         slot_q     <= slot_d;
         tx_data_q  <= tx_data_d;
         grant_q    <= grant_d;
         tx_start_q <= tx_start_d;
         timeout_q  <= timeout_d;
         wd_q       <= wd_d;
         gap_q      <= gap_d;
      end
   end

   assign req_ready = ~full_q;
   assign tx_data   = tx_data_q;
   assign tx_start  = tx_start_q;
   assign grant_id  = grant_q;
   assign busy      = (state_q != IDLE);
   assign timeout   = timeout_q;

endmodule
